// File: rtl/ws2812b_frame_controller.sv
// rtl/ws2812b_frame_controller.sv - WS2812B frame sequencer: latch-gap detection, GRB pixel capture (optional stats: WS2812B_STATS_EN)
module ws2812b_frame_controller #(
    parameter int GAP_W = 16,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din_level,
    input  logic             bit_valid,
    input  logic             bit_value,
    input  logic [7:0]       threshold_cfg,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic [IDX_W-1:0] pixel_index,
    input  logic             clr,
    output logic [31:0]      dec_threshold,
    output logic             dec_reset,
    output logic [23:0]      pixel_grb,
    output logic             pixel_valid,
    output logic             frame_done,
    output logic             frame_err,
    output logic [IDX_W:0]   pixel_count,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {S_DISABLED, S_SYNC, S_RECEIVE} state_t;

    state_t           state, state_next;
    logic [GAP_W-1:0] gap_cnt, gap_eff, gap_run;
    logic             gap_evt;
    logic             receiving;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [IDX_W:0]   pix_cnt_q, pix_cnt_d;
    logic             capture, frame_gap, done_set, err_set;

    assign dec_threshold = {24'd0, threshold_cfg};

    // Gap detection: a zero threshold behaves as one; the event fires once, on the
    // cycle the low run reaches the threshold, so a long or saturated low is one event.
    always_comb begin
        gap_eff = (gap_cycles == '0) ? {{(GAP_W-1){1'b0}}, 1'b1} : gap_cycles;
        gap_run = (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;
        gap_evt = en && (state != S_DISABLED) && !din_level &&
                  (gap_run == gap_eff) && (gap_cnt != gap_eff);
    end

    // Low-run counter, idle while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          gap_cnt <= '0;
        else if (!en || state == S_DISABLED) gap_cnt <= '0;
        else if (din_level)                  gap_cnt <= '0;
        else                                 gap_cnt <= gap_run;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_DISABLED;
        else        state <= state_next;
    end

    // Next state: the first gap after enabling aligns to a frame boundary
    always_comb begin
        state_next = state;
        case (state)
            S_DISABLED: if (en) state_next = S_SYNC;
            S_SYNC:     if (gap_evt) state_next = S_RECEIVE;
            S_RECEIVE:  state_next = S_RECEIVE;
            default:    state_next = S_DISABLED;
        endcase
        if (!en) state_next = S_DISABLED;
    end

    // FSM outputs: decoder held in reset only while disabled
    always_comb begin
        dec_reset = (state == S_DISABLED);
    end

    // Bit assembly; a bit arriving with a gap is applied before the gap is processed
    always_comb begin
        receiving = en && (state == S_RECEIVE);
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pix_cnt_d = pix_cnt_q;
        capture   = 1'b0;
        if (receiving && bit_valid) begin
            shift_d = {shift_q[22:0], bit_value};
            if (bit_cnt_q == 5'd23) begin
                bit_cnt_d = 5'd0;
                capture   = (pix_cnt_q == {1'b0, pixel_index});
                if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
        frame_gap = receiving && gap_evt;
        done_set  = frame_gap && (pix_cnt_d != '0);
        err_set   = frame_gap && (bit_cnt_d != 5'd0);
    end

    // Frame datapath and sticky flags; a set beats a simultaneous clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            pixel_grb   <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            pixel_count <= '0;
        end else begin
            frame_done <= done_set;
            if (!receiving || frame_gap) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
                pix_cnt_q <= '0;
            end else begin
                shift_q   <= shift_d;
                bit_cnt_q <= bit_cnt_d;
                pix_cnt_q <= pix_cnt_d;
            end
            if (capture) pixel_grb <= shift_d;
            if (capture)  pixel_valid <= 1'b1;
            else if (clr) pixel_valid <= 1'b0;
            if (err_set)  frame_err <= 1'b1;
            else if (clr) frame_err <= 1'b0;
            if (frame_gap) pixel_count <= pix_cnt_d;
        end
    end

`ifdef WS2812B_STATS_EN
    // Lifetime statistics: frames wrap, errors saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (done_set) frame_cnt <= frame_cnt + 16'd1;
            if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule
